midi_note_controller: RTL

//  Receives a serial MIDI stream (31250 baud, 8N1) and drives one monophonic voice.

---
 rtl/midi_note_controller_pkg.sv | 28 ++
 rtl/midi_uart_rx.sv | 110 +++++++++++
 rtl/midi_note_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/midi_note_controller_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers and receiver state encoding.
// Imported by the UART receiver and the note controller.
package midi_note_controller_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_one_data(input logic [3:0] status_hi);
    return (status_hi == PROG) || (status_hi == CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI input: two-flop synchroniser, mid-bit sampling,
// one-cycle valid pulse per good byte and a one-cycle frame_error pulse on a low stop bit.
module midi_uart_rx
  import midi_note_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line that has gone high again was only a glitch.
        if (timer_q == HALF_END) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        timer_d = '0;
        if (rx_sync_q) state_d = RX_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/midi_note_controller.sv
// MIDI-in to monophonic voice: parses Note On/Off and All Notes Off with running status
// on one channel (or omni) and holds registered note, gate and velocity.
module midi_note_controller
  import midi_note_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  input  logic [3:0] midi_channel,
  input  logic       omni,
  output logic [7:0] note,
  output logic       gate,
  output logic [6:0] velocity,
  output logic       frame_error
);

  logic       byte_valid;
  logic [7:0] byte_data;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (midi_rx),
    .data        (byte_data),
    .valid       (byte_valid),
    .frame_error (frame_error)
  );

  logic [7:0] rs_q, rs_d;
  logic       rs_valid_q, rs_valid_d;
  logic       cnt_q, cnt_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic       gate_q, gate_d;
  logic [6:0] vel_q, vel_d;
  logic       msg_done;
  logic [6:0] msg_d1, msg_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
      cnt_q      <= 1'b0;
      d1_q       <= '0;
      note_q     <= '0;
      gate_q     <= 1'b0;
      vel_q      <= '0;
    end else begin
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
      cnt_q      <= cnt_d;
      d1_q       <= d1_d;
      note_q     <= note_d;
      gate_q     <= gate_d;
      vel_q      <= vel_d;
    end
  end

  always_comb begin
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q;
    cnt_d      = cnt_q;
    d1_d       = d1_q;
    note_d     = note_q;
    gate_d     = gate_q;
    vel_d      = vel_q;
    msg_done   = 1'b0;
    msg_d1     = d1_q;
    msg_d2     = byte_data[6:0];
    if (byte_valid) begin
      // Real-time bytes (F8-FF) fall through untouched; system common (F0-F7) kills running status.
      if (byte_data[7:4] == 4'hF) begin
        if (!byte_data[3]) begin
          rs_valid_d = 1'b0;
          cnt_d      = 1'b0;
        end
      end else if (byte_data[7]) begin
        rs_d       = byte_data;
        rs_valid_d = 1'b1;
        cnt_d      = 1'b0;
      end else if (rs_valid_q) begin
        if (is_one_data(rs_q[7:4])) begin
          msg_done = 1'b1;
          msg_d1   = byte_data[6:0];
        end else if (cnt_q) begin
          msg_done = 1'b1;
        end else begin
          d1_d  = byte_data[6:0];
          cnt_d = 1'b1;
        end
        if (msg_done) cnt_d = 1'b0;
      end
    end
    if (msg_done && (omni || (rs_q[3:0] == midi_channel))) begin
      case (rs_q[7:4])
        NOTE_ON: begin
          if (msg_d2 != 7'd0) begin
            note_d = msg_d1;
            vel_d  = msg_d2;
            gate_d = 1'b1;
          end else if (gate_q && (msg_d1 == note_q)) begin
            gate_d = 1'b0;
          end
        end
        NOTE_OFF: if (gate_q && (msg_d1 == note_q)) gate_d = 1'b0;
        CTRL:     if (msg_d1 == CC_ALL_NOTES_OFF) gate_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign note     = {1'b0, note_q};
  assign gate     = gate_q;
  assign velocity = vel_q;

endmodule
